// File: rtl/max_acc_pkg.sv
// Shared types and constants for the signed max-accumulate batch sequencer.
//   state_e     : controller FSM states
//   DRAIN_DEPTH : cycles spent in DRAIN after the last accepted beat
//   acc_w()     : accumulator width for a given operand width
package max_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Covers stage 2 load and the final accumulate after the last beat.
    localparam int DRAIN_DEPTH = 2;

    function automatic int acc_w(input int n);
        return 5 * n;
    endfunction

endpackage

// File: rtl/max_acc_datapath.sv
// Three-stage register -> max -> accumulate pipeline.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr_i        : synchronous clear of valid bits, operand regs and accumulator
//   load_i       : accepted beat; loads stage 1 and becomes its valid bit
//   add_en_i     : allows stage 3 to accumulate
//   a_i, b_i     : signed operands
//   acc_o        : signed accumulator, acc_w(N) bits
module max_acc_datapath
    import max_acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clr_i,
    input  logic                      load_i,
    input  logic                      add_en_i,
    input  logic signed [N-1:0]       a_i,
    input  logic signed [N-1:0]       b_i,
    output logic signed [acc_w(N)-1:0] acc_o
);

    localparam int AW = acc_w(N);

    logic signed [N-1:0]  a_q;
    logic signed [N-1:0]  b_q;
    logic signed [N-1:0]  max_q;
    logic                 v1_q;
    logic                 v2_q;
    logic signed [AW-1:0] acc_q;

    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            max_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v1_q <= load_i;
            if (load_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            v2_q <= v1_q;
            // Ties select b; both operands are signed so the compare is signed.
            if (v1_q) begin
                max_q <= (a_q > b_q) ? a_q : b_q;
            end
            if (v2_q && add_en_i) begin
                acc_q <= acc_q + {{(AW-N){max_q[N-1]}}, max_q};
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/max_acc_controller.sv
// Batch sequencer for the signed max-accumulate datapath.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; result holds the last batch sum
//   RUN   | accepting operand pairs until len beats have been taken
//   DRAIN | pipeline emptying after the last beat (DRAIN_DEPTH cycles)
//   DONE  | one-cycle done pulse; result is final
//
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start, len    : batch command (sampled only in IDLE)
//   in_valid/in_ready, a, b : operand pair handshake
//   busy          : state != IDLE
//   done          : one-cycle completion pulse
//   result        : accumulator, 5*N bits signed
module max_acc_controller
    import max_acc_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [N-1:0]        a,
    input  logic signed [N-1:0]        b,
    output logic                       busy,
    output logic                       done,
    output logic signed [acc_w(N)-1:0] result
);

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_DEPTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;     // beats still to accept
    logic [1:0]       drain_q, drain_d;
    logic             beat;
    logic             clr;
    logic             add_en;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign beat     = in_valid & in_ready;
    assign add_en   = (state_q == RUN) || (state_q == DRAIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LAST;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    max_acc_datapath #(
        .N(N)
    ) u_dp (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (clr),
        .load_i   (beat),
        .add_en_i (add_en),
        .a_i      (a),
        .b_i      (b),
        .acc_o    (result)
    );

endmodule

// File: tb/tb_max_acc_controller.sv
module tb_max_acc_controller;

    typedef struct {
        logic [7:0]  len;
        logic [15:0] as;    // beat i operand a at [4*i +: 4]
        logic [15:0] bs;
        bit          gaps;  // bubble before every beat after the first
        logic [19:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [19:0] result;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    max_acc_controller #(.N(4), .CNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called in the cycle after the last acceptance edge; done is due in the
    // third cycle after that edge.
    task automatic wait_done(input logic [19:0] exp);
        int n;
        n = 1;
        while (!done && n < 12) begin
            @(negedge clock);
            n++;
        end
        in_valid = 1'b0;
        chk("done_latency", n, 3);
        chk("result", {12'b0, result}, {12'b0, exp});
        @(negedge clock);
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("busy_after_done", {31'b0, busy}, 0);
        chk("result_hold", {12'b0, result}, {12'b0, exp});
    endtask

    task automatic run_batch(input vec_t v);
        int d0;
        d0 = done_cnt;
        @(negedge clock);
        start = 1'b1;
        len   = v.len;
        @(negedge clock);
        start = 1'b0;
        len   = 8'hAA;
        chk("busy_after_start", {31'b0, busy}, 1);
        chk("ready_after_start", {31'b0, in_ready}, {31'b0, v.len != 8'd0});
        if (v.len == 8'd0) begin
            chk("done_len0", {31'b0, done}, 1);
            chk("result_len0", {12'b0, result}, 0);
            @(negedge clock);
            chk("done_len0_off", {31'b0, done}, 0);
            chk("busy_len0_off", {31'b0, busy}, 0);
            chk("ready_len0", {31'b0, in_ready}, 0);
        end else begin
            for (int i = 0; i < int'(v.len); i++) begin
                if (v.gaps && i > 0) begin
                    in_valid = 1'b0;
                    a = 4'h7;
                    b = 4'h7;
                    @(negedge clock);
                end
                in_valid = 1'b1;
                a = v.as[4*i +: 4];
                b = v.bs[4*i +: 4];
                if (!in_ready) chk("ready_beat", {31'b0, in_ready}, 1);
                @(negedge clock);
            end
            // In the gap variant keep offering a pair that would be counted wrongly.
            if (v.gaps) begin
                in_valid = 1'b1;
                a = 4'h7;
                b = 4'h7;
            end else begin
                in_valid = 1'b0;
            end
            chk("ready_after_last", {31'b0, in_ready}, 0);
            wait_done(v.exp);
        end
        chk("done_count", done_cnt - d0, 1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{len: 8'd4, as: 16'h862B, bs: 16'h96F3, gaps: 1'b0, exp: 20'h00004};
        vecs[1] = '{len: 8'd4, as: 16'h862B, bs: 16'h96F3, gaps: 1'b1, exp: 20'h00004};
        vecs[2] = '{len: 8'd1, as: 16'h0007, bs: 16'h0008, gaps: 1'b0, exp: 20'h00007};
        vecs[3] = '{len: 8'd1, as: 16'h000F, bs: 16'h000F, gaps: 1'b0, exp: 20'hFFFFF};
        vecs[4] = '{len: 8'd2, as: 16'h00E0, bs: 16'h005D, gaps: 1'b0, exp: 20'h00005};
        vecs[5] = '{len: 8'd3, as: 16'h03C5, bs: 16'h0D45, gaps: 1'b1, exp: 20'h0000C};
        vecs[6] = '{len: 8'd0, as: 16'h0000, bs: 16'h0000, gaps: 1'b0, exp: 20'h00000};
        vecs[7] = '{len: 8'd4, as: 16'h8888, bs: 16'h7777, gaps: 1'b1, exp: 20'h0001C};

        reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; a = 4'h0; b = 4'h0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", {12'b0, result}, 0);
        reset = 1'b0;
        // Beats offered in IDLE must be ignored.
        in_valid = 1'b1; a = 4'h7; b = 4'h7;
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        chk("idle_ignore", {12'b0, result}, 0);

        for (int k = 0; k < 8; k++) run_batch(vecs[k]);

        // start pulsed during RUN must not change the length or queue a batch.
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clock); start = 1'b1; len = 8'd2;
            @(negedge clock); len = 8'd5;              // start still high in RUN
            in_valid = 1'b1; a = 4'h1; b = 4'h0;
            @(negedge clock); start = 1'b0;
            a = 4'h0; b = 4'h1;
            @(negedge clock);
            in_valid = 1'b0;
            chk("ready_after_len2", {31'b0, in_ready}, 0);
            wait_done(20'h00002);
            repeat (6) @(negedge clock);
            chk("start_in_run_done_cnt", done_cnt - d0, 1);
            chk("start_in_run_idle", {31'b0, busy}, 0);
        end

        // Reset mid-batch after two of four beats.
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clock); start = 1'b1; len = 8'd4;
            @(negedge clock); start = 1'b0;
            in_valid = 1'b1; a = 4'hB; b = 4'h3;
            @(negedge clock); a = 4'h2; b = 4'hF;
            @(negedge clock); in_valid = 1'b0;
            @(negedge clock); reset = 1'b1;
            @(negedge clock); reset = 1'b0;
            chk("abort_busy", {31'b0, busy}, 0);
            chk("abort_ready", {31'b0, in_ready}, 0);
            chk("abort_result", {12'b0, result}, 0);
            chk("abort_done", {31'b0, done}, 0);
            repeat (5) @(negedge clock);
            chk("abort_no_done", done_cnt - d0, 0);
            run_batch('{len: 8'd1, as: 16'h000D, bs: 16'h000A, gaps: 1'b0, exp: 20'hFFFFD});
        end

        // Maximum length batch of most-negative operands.
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clock); start = 1'b1; len = 8'd255;
            @(negedge clock); start = 1'b0;
            for (int i = 0; i < 255; i++) begin
                in_valid = 1'b1; a = 4'h8; b = 4'h8;
                if (!in_ready) chk("ready_255", {31'b0, in_ready}, 1);
                @(negedge clock);
            end
            in_valid = 1'b0;
            chk("ready_after_255", {31'b0, in_ready}, 0);
            wait_done(20'hFF808);
            chk("done_count_255", done_cnt - d0, 1);
            run_batch('{len: 8'd1, as: 16'h0007, bs: 16'h0000, gaps: 1'b0, exp: 20'h00007});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/max_acc_controller.md
# max_acc_controller

Batch sequencer for the signed max-accumulate datapath. Accepts a start command carrying a batch length, then takes that many operand pairs over a valid/ready handshake. Each pair goes through a 3-stage register → max → accumulate pipeline. When the pipeline has drained, the block pulses `done` with the batch sum of per-pair maxima. It sits between the operand source and any consumer of accumulated results, and owns the datapath exclusively.

## Interface
- `N`, 4, operand width in bits (signed two's complement)
- `CNT_W`, 8, batch length counter width; legal only when CNT_W + N ≤ 5*N, which guarantees the sum never overflows
- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset; synchronous, active-high. One clock; all state resets on the edge where `reset`=1.
- `start`  in  1  command strobe; sampled only in IDLE
- `len`  in  CNT_W  number of pairs in the batch (unsigned); sampled with `start`
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  block accepts a pair this cycle
- `a`, `b`  in  N  signed operands
- `busy`  out  1  batch in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse; `result` is final
- `result`  out  5*N  signed accumulator value

## Operation
- States:
  - IDLE → RUN on `start` with `len`≠0.
  - IDLE → DONE on `start` with `len`=0.
  - RUN → DRAIN when the beat that makes the accepted count equal `len` is accepted.
  - DRAIN → DONE after exactly 2 cycles.
  - DONE → IDLE unconditionally.
- On an accepted `start`: latch `len`, clear the beat counter, clear the accumulator to 0, clear the pipeline valid bits.
- `in_ready` = (state == RUN). A beat is accepted when `in_valid` & `in_ready`. Beats offered in any other state are ignored and not stored.
- Pipeline and valid bits:
  - Stage 1 registers `a`, `b` with valid v1 = accepted beat.
  - Stage 2 registers max(a,b) with v2 = v1. Signed compare: a > b selects a, otherwise b.
  - Stage 3 does acc ← acc + sign-extended max, only when v2=1.
- Bubbles (`in_valid`=0 in RUN) propagate as invalid and add nothing.
- `start` outside IDLE is ignored, including in the DONE cycle. Never queued.
- `result` = accumulator at all times. It holds the last batch value after DONE until the next accepted `start` clears it.
- Arithmetic: operands sign-extended from N to 5*N bits. No saturation needed within the legal parameter range.
- Reset in any state (mid-RUN or DRAIN included): go to IDLE, acc=0, pipeline cleared, partial batch discarded. No `done` is issued for the aborted batch.
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `result`=0.

## Timing
- `start` accepted at edge t0 → `in_ready`=1 and `busy`=1 in the cycle after t0.
- Throughput: one pair per cycle, with no dead cycles between beats.
- Last beat accepted at edge k:
  - `in_ready`=0 from the cycle after k.
  - Stage 2 loads at k+1; acc updates at k+2.
  - `done`=1 and `result` final during the cycle after k+2.
  - `busy` falls after edge k+3.
- `len`=0: `start` at t0 → `done`=1 in the cycle after t0 with `result`=0. `in_ready` never rises.
- `done` is never high for more than one cycle. Back-to-back batches: the earliest next `start` is sampled in the cycle after `done`.

## Structure
- Package `max_acc_pkg`:
  - state enum typedef (IDLE, RUN, DRAIN, DONE)
  - `ACC_W` = 5*N width helper
  - drain-depth constant = 2
- Sub-module `max_acc_datapath`: 3-stage pipeline with v1/v2 valid bits, synchronous clear input, and add-enable. The controller holds the FSM, length/beat counter and drain counter.

## Test plan
- N=4, `len`=4, pairs (-5,3), (2,-1), (6,6), (-8,-7), back-to-back → maxima 3, 2, 6, -7. `done` pulses in the 3rd cycle after the last acceptance edge with `result`=4. `busy` drops the next cycle.
- Same pairs with `in_valid` low every other cycle → `result`=4. `done` comes 3 cycles after the last accepted beat. Beats offered while `in_ready`=0 are not counted.
- `len`=0 → `done` in the cycle after `start`, `result`=0, `in_ready` stays 0. A `start` pulsed during RUN is ignored: the batch length is unchanged and there is no second `done`.
- Reset asserted after 2 of 4 beats → next cycle `busy`=0, `in_ready`=0, `result`=0, no `done`. Then `len`=1 with pair (-3,-6) → `result`=-3 (20'hFFFFD).
- `len`=255, all pairs (-8,-8) → `result`=-2040 (20'hFF808), exactly one `done`. A following batch `len`=1 with pair (7,0) → `result`=7, confirming the clear on `start`.
